fpmult_arbiter: RTL

- Shares one fpmult instance between NREQ requesters, such as synth voices and envelope/gain stages.
- Arbitration is round-robin. Each requester uses a req/ack handshake.
- The arbiter sequences the multiplier's start-by-reset protocol: hold reset high, release, wait for done.
- The result is returned to the granted requester with a one-cycle ack pulse.

---
 rtl/fpmult_arbiter_if.sv | 33 +++
 rtl/fpmult_arbiter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/fpmult_arbiter_if.sv
// fpmult_arbiter_if
// Bundles the requester-side and multiplier-side signals of fpmult_arbiter.
//   master : environment view (requesters + fpmult) - drives req, dataa, datab,
//            mult_result, mult_done; observes everything else.
//   slave  : arbiter view - drives ack, result, busy, err, mult_reset,
//            mult_dataa, mult_datab.
// Operand buses pack requester i at bits [32*i+31:32*i].
interface fpmult_arbiter_if #(
  parameter int NREQ = 4
) ();
  logic [NREQ-1:0]      req;
  logic [32*NREQ-1:0]   dataa;
  logic [32*NREQ-1:0]   datab;
  logic [NREQ-1:0]      ack;
  logic [31:0]          result;
  logic                 busy;
  logic [NREQ-1:0]      err;
  logic                 mult_reset;
  logic [31:0]          mult_dataa;
  logic [31:0]          mult_datab;
  logic [31:0]          mult_result;
  logic                 mult_done;

  modport master (
    output req, dataa, datab, mult_result, mult_done,
    input  ack, result, busy, err, mult_reset, mult_dataa, mult_datab
  );

  modport slave (
    input  req, dataa, datab, mult_result, mult_done,
    output ack, result, busy, err, mult_reset, mult_dataa, mult_datab
  );
endinterface

// File: rtl/fpmult_arbiter.sv
// fpmult_arbiter
// Shares one fpmult instance between NREQ requesters with round-robin
// arbitration. A granted operation latches the requester's operands, holds the
// multiplier in reset for START_CYCLES cycles (its start strobe), releases it,
// waits for mult_done and returns the product with a one-cycle ack pulse.
// Ports:
//   clk    : clock
//   reset  : asynchronous active-high reset
//   bus    : fpmult_arbiter_if.slave - req/dataa/datab/ack/result/busy/err on
//            the requester side, mult_* on the multiplier side.
// Optional feature: define FPMULT_ARB_TIMEOUT_EN to add a WAIT watchdog of
// TIMEOUT cycles that answers with a quiet NaN and an err pulse. Without the
// macro err is constant 0 and WAIT waits indefinitely.
module fpmult_arbiter #(
  parameter int NREQ         = 4,
  parameter int START_CYCLES = 1,
  parameter int TIMEOUT      = 64
) (
  input  logic           clk,
  input  logic           reset,
  fpmult_arbiter_if.slave bus
);

  localparam int PW  = $clog2(NREQ);
  localparam int SCW = (START_CYCLES > 1) ? $clog2(START_CYCLES) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  localparam logic [31:0] QNAN = 32'h7fc00000;

  if (NREQ < 2 || NREQ > 16 || START_CYCLES < 1 || TIMEOUT < 1) begin : g_param_check
    $error("fpmult_arbiter: parameter out of range");
  end

  logic [1:0]      state_reg;
  logic [PW-1:0]   rr_ptr_reg;
  logic [PW-1:0]   grant_reg;
  logic [SCW-1:0]  start_cnt_reg;
  logic [NREQ-1:0] ack_reg;
  logic [31:0]     result_reg;
  logic            busy_reg;
  logic            mult_reset_reg;
  logic [31:0]     mult_dataa_reg;
  logic [31:0]     mult_datab_reg;

`ifdef FPMULT_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TW-1:0]   wait_cnt_reg;
  logic [NREQ-1:0] err_reg;
`endif

  // Unpacked views of the packed operand buses and a one-hot of the grant.
  logic [31:0]     a_arr [NREQ];
  logic [31:0]     b_arr [NREQ];
  logic [NREQ-1:0] grant_onehot;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]        = bus.dataa[32*gi +: 32];
    assign b_arr[gi]        = bus.datab[32*gi +: 32];
    assign grant_onehot[gi] = (grant_reg == PW'(gi));
  end

  // Round-robin pick: first set req bit at offset 0..NREQ-1 from rr_ptr.
  // Scanning offsets downward lets the smallest offset win.
  logic          grant_found;
  logic [PW-1:0] grant_idx;
  logic [PW:0]   idx_c;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    idx_c       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx_c = {1'b0, rr_ptr_reg} + (PW+1)'(k);
      if (idx_c >= (PW+1)'(NREQ)) begin
        idx_c = idx_c - (PW+1)'(NREQ);
      end
      if (bus.req[idx_c[PW-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = idx_c[PW-1:0];
      end
    end
  end

  logic [PW-1:0] ptr_next;
  assign ptr_next = (grant_reg == PW'(NREQ - 1)) ? '0 : grant_reg + PW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= '0;
      grant_reg      <= '0;
      start_cnt_reg  <= '0;
      ack_reg        <= '0;
      result_reg     <= '0;
      busy_reg       <= 1'b0;
      mult_reset_reg <= 1'b1;
      mult_dataa_reg <= '0;
      mult_datab_reg <= '0;
`ifdef FPMULT_ARB_TIMEOUT_EN
      wait_cnt_reg   <= '0;
      err_reg        <= '0;
`endif
    end else begin
      // ack/err are single-cycle pulses; only the WAIT exit raises them.
      ack_reg <= '0;
`ifdef FPMULT_ARB_TIMEOUT_EN
      err_reg <= '0;
`endif
      case (state_reg)
        IDLE: begin
          mult_reset_reg <= 1'b1;
          busy_reg       <= 1'b0;
          if (grant_found) begin
            grant_reg      <= grant_idx;
            mult_dataa_reg <= a_arr[grant_idx];
            mult_datab_reg <= b_arr[grant_idx];
            busy_reg       <= 1'b1;
            start_cnt_reg  <= '0;
            state_reg      <= START;
          end
        end
        START: begin
          // mult_reset stays high for START_CYCLES cycles counted from entry.
          if (start_cnt_reg == SCW'(START_CYCLES - 1)) begin
            mult_reset_reg <= 1'b0;
            state_reg      <= WAIT;
`ifdef FPMULT_ARB_TIMEOUT_EN
            wait_cnt_reg   <= '0;
`endif
          end else begin
            start_cnt_reg <= start_cnt_reg + SCW'(1);
          end
        end
        WAIT: begin
          if (bus.mult_done) begin
            result_reg <= bus.mult_result;
            ack_reg    <= grant_onehot;
            state_reg  <= RESP;
          end
`ifdef FPMULT_ARB_TIMEOUT_EN
          // The TIMEOUT-th WAIT cycle without done gives up.
          else if (wait_cnt_reg == TW'(TIMEOUT - 1)) begin
            result_reg <= QNAN;
            ack_reg    <= grant_onehot;
            err_reg    <= grant_onehot;
            state_reg  <= RESP;
          end else begin
            wait_cnt_reg <= wait_cnt_reg + TW'(1);
          end
`endif
        end
        RESP: begin
          busy_reg       <= 1'b0;
          mult_reset_reg <= 1'b1;
          rr_ptr_reg     <= ptr_next;
          state_reg      <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.ack        = ack_reg;
  assign bus.result     = result_reg;
  assign bus.busy       = busy_reg;
  assign bus.mult_reset = mult_reset_reg;
  assign bus.mult_dataa = mult_dataa_reg;
  assign bus.mult_datab = mult_datab_reg;
`ifdef FPMULT_ARB_TIMEOUT_EN
  assign bus.err        = err_reg;
`else
  assign bus.err        = '0;
`endif

endmodule
